// File: rtl/pipeline_control.sv
// Hazard/stall/flush controller for a five-stage pipeline with a RUN/MEMWAIT/HALTED FSM.
// Define PIPECTRL_PERF_EN to build in the saturating stall/flush performance counters.
module pipeline_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dmem_req,
  input  logic        dhit,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        memwb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halt,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_next;
  logic       halt_q;
  logic       load_use;

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // Priority resolution; a pending dcache miss freezes everything, even a taken branch.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_next  = state_q;
    case (state_q)
      RUN, MEMWAIT: begin
        if ((state_q == MEMWAIT) && !dhit) begin
          state_next = MEMWAIT;
        end else if (memwb_halt) begin
          state_next = HALTED;
        end else if ((state_q == RUN) && dmem_req && !dhit) begin
          state_next = MEMWAIT;
        end else begin
          state_next = RUN;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (jump) begin
            pc_en      = ihit;
            ifid_flush = 1'b1;
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      if (state_next == HALTED) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign state = state_q;
  assign halt  = halt_q;

`ifdef PIPECTRL_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;
  logic        flush_event;

  // exmem_flush only comes from a taken branch; ifid_flush with jump set only from branch or jump.
  assign flush_event = exmem_flush || (jump && ifid_flush);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      if ((state_q != HALTED) && !pc_en && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (flush_event && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Table-driven bench for pipeline_control with a queue scoreboard and a counter model.
// Follows PIPECTRL_PERF_EN: counters are expected to be modelled values or constant zero.
module tb_pipeline_control;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dmem_req, dhit, idex_memread;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        ifid_uses_rt, branch_taken, jump, memwb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halt;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;

`ifdef PIPECTRL_PERF_EN
  localparam bit PERF = 1'b1;
  localparam int SAT_CYCLES = 70000;
`else
  localparam bit PERF = 1'b0;
  localparam int SAT_CYCLES = 2000;
`endif

  pipeline_control dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken), .jump(jump),
    .memwb_halt(memwb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt(halt), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       ihit, dmemReq, dhit, idexMemread;
    logic [4:0] idexRt, ifidRs, ifidRt;
    logic       ifidUsesRt, branchTaken, jump, memwbHalt;
    logic [4:0] expEn;
    logic [2:0] expFlush;
    logic [1:0] expState;
    logic       flushEv;
  } vec_t;

  vec_t expQ[$];
  vec_t vecTable[$];
  int   compared = 0;
  int   mismatched = 0;
  logic [1:0] modelState;
  int   expStall, expFlushCnt;

  function automatic vec_t mk(string n, logic ih, logic dr, logic dh, logic mr,
                              logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt, logic urt,
                              logic br, logic jp, logic hl, logic [4:0] en,
                              logic [2:0] fl, logic [1:0] st, logic fe);
    vec_t v;
    v.name = n; v.ihit = ih; v.dmemReq = dr; v.dhit = dh; v.idexMemread = mr;
    v.idexRt = xrt; v.ifidRs = rs; v.ifidRt = rt; v.ifidUsesRt = urt;
    v.branchTaken = br; v.jump = jp; v.memwbHalt = hl;
    v.expEn = en; v.expFlush = fl; v.expState = st; v.flushEv = fe;
    return v;
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ihit = v.ihit; dmem_req = v.dmemReq; dhit = v.dhit; idex_memread = v.idexMemread;
    idex_rt = v.idexRt; ifid_rs = v.ifidRs; ifid_rt = v.ifidRt;
    ifid_uses_rt = v.ifidUsesRt; branch_taken = v.branchTaken; jump = v.jump;
    memwb_halt = v.memwbHalt;
    expQ.push_back(v);
  endtask

  // Combinational outputs sampled mid-cycle; registered ones 1 time unit after the edge.
  task automatic checkOutput();
    vec_t e;
    #4;
    if (expQ.size() == 0) begin
      check("scoreboard_empty", 32'(1), 32'(0));
      return;
    end
    e = expQ.pop_front();
    check({e.name, "_en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(e.expEn));
    check({e.name, "_flush"}, 32'({ifid_flush, idex_flush, exmem_flush}), 32'(e.expFlush));
    @(posedge CLK);
    #1;
    if (modelState != 2'd2 && e.expEn[4] == 1'b0 && expStall < 65535) expStall++;
    if (e.flushEv && expFlushCnt < 65535) expFlushCnt++;
    modelState = e.expState;
    check({e.name, "_state"}, 32'(state), 32'(e.expState));
    check({e.name, "_halt"}, 32'(halt), 32'(modelState == 2'd2));
    check({e.name, "_stallcnt"}, 32'(stall_count), PERF ? 32'(expStall) : 32'(0));
    check({e.name, "_flushcnt"}, 32'(flush_count), PERF ? 32'(expFlushCnt) : 32'(0));
  endtask

  task automatic cycle(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must clear without a clock edge.
  task automatic pulseReset(input string n);
    nRST = 1'b0;
    ihit = 1'b1; branch_taken = 1'b1; memwb_halt = 1'b1; jump = 1'b1;
    #2;
    check({n, "_en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(0));
    check({n, "_flush"}, 32'({ifid_flush, idex_flush, exmem_flush}), 32'(0));
    check({n, "_state"}, 32'(state), 32'(0));
    check({n, "_halt"}, 32'(halt), 32'(0));
    check({n, "_stallcnt"}, 32'(stall_count), 32'(0));
    check({n, "_flushcnt"}, 32'(flush_count), 32'(0));
    modelState = 2'd0; expStall = 0; expFlushCnt = 0;
    nRST = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    vec_t p7, missC, satV;
    nRST = 1'b0;
    ihit = 1'b1; dmem_req = 1'b1; dhit = 1'b0; idex_memread = 1'b1;
    idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    branch_taken = 1'b1; jump = 1'b1; memwb_halt = 1'b1;
    modelState = 2'd0; expStall = 0; expFlushCnt = 0;

    @(posedge CLK);
    #1;
    check("reset_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(0));
    check("reset_flush", 32'({ifid_flush, idex_flush, exmem_flush}), 32'(0));
    check("reset_state", 32'(state), 32'(0));
    check("reset_halt", 32'(halt), 32'(0));
    check("reset_stallcnt", 32'(stall_count), 32'(0));
    check("reset_flushcnt", 32'(flush_count), 32'(0));
    #2;
    nRST = 1'b1;

    vecTable.push_back(mk("p7_plain",      1,0,0,0, 0, 0, 0,0, 0,0,0, 5'b11111, 3'b000, 0, 0));
    vecTable.push_back(mk("p6_imiss",      0,0,0,0, 0, 0, 0,0, 0,0,0, 5'b01111, 3'b100, 0, 0));
    vecTable.push_back(mk("p5_jump",       1,0,0,0, 0, 0, 0,0, 0,1,0, 5'b11111, 3'b100, 0, 1));
    vecTable.push_back(mk("p5_jump_imiss", 0,0,0,0, 0, 0, 0,0, 0,1,0, 5'b01111, 3'b100, 0, 1));
    vecTable.push_back(mk("p4_rs",         1,0,0,1, 5, 5, 0,0, 0,0,0, 5'b00111, 3'b010, 0, 0));
    vecTable.push_back(mk("p4_rt",         1,0,0,1, 9, 3, 9,1, 0,0,0, 5'b00111, 3'b010, 0, 0));
    vecTable.push_back(mk("nodep_r0",      1,0,0,1, 0, 0, 0,1, 0,0,0, 5'b11111, 3'b000, 0, 0));
    vecTable.push_back(mk("nodep_nort",    1,0,0,1, 7, 3, 7,0, 0,0,0, 5'b11111, 3'b000, 0, 0));
    vecTable.push_back(mk("nodep_noload",  1,0,0,0, 5, 5, 5,1, 0,0,0, 5'b11111, 3'b000, 0, 0));
    vecTable.push_back(mk("nodep_other",   1,0,0,1, 6, 2, 4,1, 0,0,0, 5'b11111, 3'b000, 0, 0));
    vecTable.push_back(mk("p3_branch",     1,0,0,0, 0, 0, 0,0, 1,0,0, 5'b11111, 3'b111, 0, 1));
    vecTable.push_back(mk("p3_over_p4p5",  0,0,0,1, 5, 5, 0,0, 1,1,0, 5'b11111, 3'b111, 0, 1));
    vecTable.push_back(mk("p4_over_p5",    1,0,0,1, 5, 5, 0,0, 0,1,0, 5'b00111, 3'b010, 0, 0));
    vecTable.push_back(mk("p4_imiss",      0,0,0,1, 5, 5, 0,0, 0,0,0, 5'b00111, 3'b010, 0, 0));
    vecTable.push_back(mk("dmem_hit",      1,1,1,0, 0, 0, 0,0, 0,0,0, 5'b11111, 3'b000, 0, 0));
    vecTable.push_back(mk("dmem_hit_br",   1,1,1,0, 0, 0, 0,0, 1,0,0, 5'b11111, 3'b111, 0, 1));
    for (int i = 0; i < vecTable.size(); i++) cycle(vecTable[i]);

    p7    = mk("p7_after",  1,0,0,0, 0,0,0,0, 0,0,0, 5'b11111, 3'b000, 0, 0);
    missC = mk("miss_c1",   1,1,0,0, 0,0,0,0, 0,0,0, 5'b00000, 3'b000, 1, 0);

    // Three-cycle dcache miss, then completion.
    cycle(missC);
    cycle(mk("miss_c2",     1,1,0,0, 0,0,0,0, 0,0,0, 5'b00000, 3'b000, 1, 0));
    cycle(mk("miss_c3",     1,1,0,0, 0,0,0,0, 0,0,0, 5'b00000, 3'b000, 1, 0));
    cycle(mk("miss_done",   1,1,1,0, 0,0,0,0, 0,0,0, 5'b11111, 3'b000, 0, 0));

    // Taken branch held during a miss: frozen first, flushes on the hit.
    cycle(mk("brmiss_c1",   1,1,0,0, 0,0,0,0, 1,0,0, 5'b00000, 3'b000, 1, 0));
    cycle(mk("brmiss_c2",   1,1,0,0, 0,0,0,0, 1,0,0, 5'b00000, 3'b000, 1, 0));
    cycle(mk("brmiss_done", 1,1,1,0, 0,0,0,0, 1,0,0, 5'b11111, 3'b111, 0, 1));

    // Hazard rules still apply on the completing MEMWAIT cycle.
    cycle(missC);
    cycle(mk("mw_loaduse",  1,1,1,1, 5,5,0,0, 0,0,0, 5'b00111, 3'b010, 0, 0));
    cycle(missC);
    cycle(mk("mw_jump",     1,1,1,0, 0,0,0,0, 0,1,0, 5'b11111, 3'b100, 0, 1));

    // Reset while waiting on the dcache.
    cycle(missC);
    pulseReset("rst_memwait");
    cycle(p7);

    // Halt from RUN, stays halted, then reset.
    cycle(mk("halt_run",    1,0,0,0, 0,0,0,0, 1,0,1, 5'b00000, 3'b000, 2, 0));
    cycle(mk("halted_1",    0,1,0,0, 0,0,0,0, 1,1,0, 5'b00000, 3'b000, 2, 0));
    cycle(mk("halted_2",    1,0,0,0, 0,0,0,0, 0,0,0, 5'b00000, 3'b000, 2, 0));
    pulseReset("rst_halted");
    cycle(p7);

    // Halt arriving on the completing MEMWAIT cycle.
    cycle(missC);
    cycle(mk("mw_halt",     1,1,1,0, 0,0,0,0, 0,0,1, 5'b00000, 3'b000, 2, 0));
    cycle(mk("mw_halted",   1,0,0,0, 0,0,0,0, 0,0,0, 5'b00000, 3'b000, 2, 0));
    pulseReset("rst_halted2");
    cycle(p6Prep());

    // Long icache miss: stall counter saturation.
    satV = mk("sat", 0,0,0,0, 0,0,0,0, 0,0,0, 5'b01111, 3'b100, 0, 0);
    applyStimulus(satV);
    void'(expQ.pop_front());
    bad = 0;
    for (int i = 0; i < SAT_CYCLES; i++) begin
      @(posedge CLK);
      #1;
      if (expStall < 65535) expStall++;
      if (stall_count !== (PERF ? 16'(expStall) : 16'h0000)) bad++;
    end
    check("sat_track_errors", 32'(bad), 32'(0));
    check("sat_final", 32'(stall_count), PERF ? 32'h0000FFFF : 32'(0));
    cycle(mk("sat_hold", 0,0,0,0, 0,0,0,0, 0,0,0, 5'b01111, 3'b100, 0, 0));
    cycle(mk("sat_hold2", 1,0,0,1, 5,5,0,0, 0,0,0, 5'b00111, 3'b010, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  function automatic vec_t p6Prep();
    return mk("p6_after_rst", 0,0,0,0, 0,0,0,0, 0,0,0, 5'b01111, 3'b100, 0, 0);
  endfunction

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, declared as the first two ports below.
REQ-002 CLK  in  1  clock; all state updates on its rising edge.
REQ-003 nRST  in  1  async active-low reset.
REQ-004 ihit  in  1  icache returns a valid instruction this cycle.
REQ-005 dmem_req  in  1  EX/MEM holds a load or store.
REQ-006 dhit  in  1  dcache completes the EX/MEM access this cycle.
REQ-007 idex_memread  in  1  ID/EX holds a load.
REQ-008 idex_rt  in  5  load destination register in ID/EX.
REQ-009 ifid_rs, ifid_rt  in  5 each  source registers of the IF/ID instruction.
REQ-010 ifid_uses_rt  in  1  IF/ID instruction reads rt.
REQ-011 branch_taken  in  1  taken branch resolved in EX/MEM (PC redirect).
REQ-012 jump  in  1  jump resolved in ID.
REQ-013 memwb_halt  in  1  halt instruction in MEM/WB.
REQ-014 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
REQ-015 ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble into that latch.
REQ-016 halt  out  1  registered core-halted flag.
REQ-017 state  out  2  FSM state: RUN=0, MEMWAIT=1, HALTED=2.
REQ-018 stall_count, flush_count  out  16 each  performance counters.

Function
REQ-019 The FSM SHALL have states RUN, MEMWAIT and HALTED; the value 3 SHALL never occur.
REQ-020 Enables and flushes SHALL be combinational from state and inputs; in RUN, and in MEMWAIT with dhit=1, the first matching rule below SHALL apply.
REQ-021 P1, memwb_halt=1: all enables 0, flushes 0, next state HALTED.
REQ-022 P2, dmem_req=1 and dhit=0: all enables 0, flushes 0, next state MEMWAIT.
REQ-023 P3, branch_taken=1: all enables 1, ifid_flush, idex_flush and exmem_flush all 1.
REQ-024 P4, load-use hazard (idex_memread=1, idex_rt!=0, and idex_rt==ifid_rs or (ifid_uses_rt=1 and idex_rt==ifid_rt)): pc_en=0, ifid_en=0, idex_flush=1, idex_en=exmem_en=memwb_en=1.
REQ-025 P5, jump=1: pc_en=ihit, ifid_flush=1, other enables 1.
REQ-026 P6, ihit=0: pc_en=0, ifid_flush=1, other enables 1.
REQ-027 P7, otherwise: all enables 1, flushes 0.
REQ-028 MEMWAIT with dhit=0: all enables 0, flushes 0, stay in MEMWAIT.
REQ-029 MEMWAIT with dhit=1: P1 and P3-P7 apply (P2 skipped), and the next state SHALL be RUN unless P1 fires.
REQ-030 HALTED: all enables 0, flushes 0; stay in HALTED until reset.
REQ-031 halt SHALL go to 1 on the clock edge that enters HALTED and SHALL stay 1.
REQ-032 A flush and a freeze SHALL never be asserted together; a freeze (P2) outranks branch_taken.
REQ-033 Any RUN cycle resolved by P2 SHALL forward no instruction; it retires nothing.

Reset
REQ-034 While nRST=0: state=RUN, halt=0, counters=0, all enables 0, all flushes 0, regardless of other inputs.
REQ-035 If nRST is asserted mid-MEMWAIT or while HALTED, the block SHALL return to RUN with no pending state.
REQ-036 On the first edge after nRST rises, REQ-020 rules SHALL apply from RUN.

Configuration
REQ-037 The macro PIPECTRL_PERF_EN SHALL compile the performance counters in or out.
REQ-038 With PIPECTRL_PERF_EN defined, stall_count SHALL increment on each non-HALTED cycle with pc_en=0, saturating at 0xFFFF.
REQ-039 With PIPECTRL_PERF_EN defined, flush_count SHALL increment on each cycle where P3 fires or P5 fires with ifid_flush=1, saturating at 0xFFFF.
REQ-040 Without PIPECTRL_PERF_EN, no counter registers SHALL exist and both count outputs SHALL be tied to 16'h0000; ports SHALL remain present.

Verification
REQ-041 Load-use: idex_memread=1, idex_rt=5, ifid_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_count +1.
REQ-042 dcache miss: dmem_req=1, dhit=0 for 3 cycles then dhit=1 -> state=1 for 3 cycles with all enables 0, then enables 1 and state=0; stall_count +3.
REQ-043 Branch during miss: dmem_req=1, dhit=0, branch_taken=1 -> no flush; the branch takes effect on the dhit=1 cycle with all three flushes 1; flush_count +1.
REQ-044 False dependency: idex_memread=1, idex_rt=0, ifid_rs=0 -> no stall; idex_rt=7, ifid_rt=7, ifid_uses_rt=0 -> no stall.
REQ-045 Halt then reset: memwb_halt=1 -> halt=1 and state=2 next cycle, all enables 0; pulse nRST=0 mid-cycle -> halt=0, state=0 immediately.
REQ-046 Saturation (PIPECTRL_PERF_EN defined): hold ihit=0 for 70000 cycles -> stall_count=0xFFFF and stays there; macro undefined -> stall_count=0 throughout.
